// File: rtl/bz_deserializer.sv
`default_nettype none
// ============================================================================
//  Module      : bz_deserializer
//  Description : Return-path BZ-to-PC stage. Pops 11-bit BZ words (10-bit
//                payload + tail flag) from a show-ahead FIFO, reassembles
//                each wormhole packet into one PC word and presents it on a
//                valid/ack channel toward the PC-side router.
//  Revision    : 1.0 - initial release
// ============================================================================
module bz_deserializer #(
   parameter int NCODE = 8,    // route/code bits carried in the header word
   parameter int NDATA = 24,   // assembled data field width
   parameter int NBZ   = 10    // payload bits per BZ word
) (
   input  logic                         clk,
   input  logic                         reset,     // asynchronous, active low
   input  logic [NBZ:0]                 data_in,   // FIFO head word
   input  logic                         is_empty,
   output logic                         rdreq,
   output logic                         out_v,
   output logic [NCODE+NDATA+NBZ-1:0]   out_d,
   input  logic                         out_a
);

   // Number of body words that can carry data; later body words only set trunc.
   localparam int MAXWORDS = (NDATA + NBZ - 1) / NBZ;
   localparam int CW       = $clog2(MAXWORDS + 1);
   localparam int NPC      = NCODE + NDATA + NBZ;

   typedef enum logic [1:0] {
      S_HEAD = 2'd0,
      S_BODY = 2'd1,
      S_EMIT = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [NCODE-1:0] r_code;
   logic [NCODE-1:0] w_code_nxt;
   logic [NDATA-1:0] r_data;
   logic [NDATA-1:0] w_data_nxt;
   logic [NDATA-1:0] w_data_slot;
   logic [CW-1:0]    r_count;
   logic [CW-1:0]    w_count_nxt;
   logic             r_trunc;
   logic             w_trunc_nxt;
   logic             r_out_v;
   logic             w_out_v_nxt;
   logic [NPC-1:0]   r_out_d;
   logic [NPC-1:0]   w_out_d_nxt;

   logic             w_tail;
   logic [NBZ-1:0]   w_payload;
   logic             w_pop;
   logic             w_xfer;

   assign w_tail    = data_in[NBZ];
   assign w_payload = data_in[NBZ-1:0];

   // The FIFO is never read while a finished packet waits for its ack, and
   // never while reset is held, even though the state register is already HEAD.
   assign rdreq  = reset & ~is_empty & (r_state != S_EMIT);
   assign w_pop  = rdreq;
   assign w_xfer = r_out_v & out_a;

   assign out_v = r_out_v;
   assign out_d = r_out_d;

   // Data field with the current payload merged into the slot selected by
   // count; the top slot keeps only the payload bits that fit in NDATA.
   for (genvar i = 0; i < NDATA; i++) begin : g_data_bit
      localparam logic [CW-1:0] c_slot = CW'(i / NBZ);
      assign w_data_slot[i] = (r_count == c_slot) ? w_payload[i % NBZ] : r_data[i];
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_HEAD;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state, packet assembly and output-word formation.
   always_comb begin
      w_state_nxt = r_state;
      w_code_nxt  = r_code;
      w_data_nxt  = r_data;
      w_count_nxt = r_count;
      w_trunc_nxt = r_trunc;
      w_out_v_nxt = r_out_v;
      w_out_d_nxt = r_out_d;

      case (r_state)
         S_HEAD: begin
            if (w_pop) begin
               w_code_nxt  = w_payload[NCODE-1:0];
               w_data_nxt  = '0;
               w_count_nxt = '0;
               w_trunc_nxt = 1'b0;
               w_state_nxt = w_tail ? S_EMIT : S_BODY;
            end
         end
         S_BODY: begin
            if (w_pop) begin
               if (r_count < CW'(MAXWORDS)) begin
                  w_data_nxt  = w_data_slot;
                  w_count_nxt = r_count + 1'b1;
               end else begin
                  // Packet longer than the data field: drop payload, flag it.
                  w_trunc_nxt = 1'b1;
               end
               if (w_tail) begin
                  w_state_nxt = S_EMIT;
               end
            end
         end
         S_EMIT: begin
            if (w_xfer) begin
               w_out_v_nxt = 1'b0;
               w_data_nxt  = '0;
               w_count_nxt = '0;
               w_trunc_nxt = 1'b0;
               w_state_nxt = S_HEAD;
            end
         end
         default: begin
            w_state_nxt = S_HEAD;
         end
      endcase

      // Capture the output word on the edge that pops the tail, so out_d is
      // registered and frozen for the whole time out_v is high.
      if ((r_state != S_EMIT) && (w_state_nxt == S_EMIT)) begin
         w_out_v_nxt = 1'b1;
         w_out_d_nxt = {w_code_nxt, w_data_nxt, w_trunc_nxt, (NBZ-1)'(w_count_nxt)};
      end
   end

   // Datapath and output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_code  <= '0;
         r_data  <= '0;
         r_count <= '0;
         r_trunc <= 1'b0;
         r_out_v <= 1'b0;
         r_out_d <= '0;
      end else begin
         r_code  <= w_code_nxt;
         r_data  <= w_data_nxt;
         r_count <= w_count_nxt;
         r_trunc <= w_trunc_nxt;
         r_out_v <= w_out_v_nxt;
         r_out_d <= w_out_d_nxt;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_bz_deserializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bz_deserializer
//  Description : Self-checking bench for bz_deserializer. A queue-based FIFO
//                model feeds the DUT; expected PC words go to a scoreboard
//                queue when packets are pushed and are compared on transfer.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_bz_deserializer;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [10:0] data_in;
   logic        is_empty;
   logic        rdreq;
   logic        out_v;
   logic [41:0] out_d;
   logic        out_a;

   always #5 clk = ~clk;

   bz_deserializer dut (
      .clk      (clk),
      .reset    (reset),
      .data_in  (data_in),
      .is_empty (is_empty),
      .rdreq    (rdreq),
      .out_v    (out_v),
      .out_d    (out_d),
      .out_a    (out_a)
   );

   typedef struct {
      logic [10:0] w;
      int          gap;   // empty cycles shown before this word reaches the head
   } ent_t;

   ent_t        fifo[$];
   logic [41:0] exp_q[$];

   int          vectors = 0;
   int          miscompares = 0;
   int          cyc = 0;
   int          pop_cnt = 0;
   int          pop0 = 0;
   int          head_wait = 0;
   int          last_pop_edge = -1;
   int          last_xfer_edge = -1;
   int          v_rise_edge = -1;
   int          v_cycles = 0;
   logic        prev_v = 1'b0;
   logic        s_rdreq;
   logic [41:0] s_outd;
   logic [41:0] last_xfer_d = '0;
   logic [41:0] hold_d;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_inputs();
      is_empty = (fifo.size() == 0) || (head_wait > 0);
      data_in  = (fifo.size() != 0) ? fifo[0].w : 11'h000;
   endtask

   task automatic push_word(input logic [10:0] w, input int gap);
      ent_t e;
      e.w   = w;
      e.gap = gap;
      if (fifo.size() == 0) head_wait = gap;
      fifo.push_back(e);
      drive_inputs();
   endtask

   // One clock: sample at the falling edge, then update the FIFO model 1ns
   // after the rising edge.
   task automatic tick();
      logic popped;
      logic xfer;
      @(negedge clk);
      s_rdreq = rdreq;
      s_outd  = out_d;
      popped  = rdreq;
      xfer    = out_v && out_a;
      check("rdreq_while_empty", {63'b0, rdreq & is_empty}, 64'd0);
      if (out_v && !prev_v) v_rise_edge = cyc;
      if (out_v) v_cycles++;
      prev_v = out_v;
      if (xfer) begin
         last_xfer_d = out_d;
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL unexpected_output observed=%0h expected=none", out_d);
         end else begin
            check("out_d_scoreboard", out_d, exp_q.pop_front());
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      if (popped) begin
         if (fifo.size() != 0) fifo.delete(0);
         pop_cnt++;
         last_pop_edge = cyc;
         head_wait = (fifo.size() != 0) ? fifo[0].gap : 0;
      end else if (head_wait > 0) begin
         head_wait--;
      end
      if (xfer) last_xfer_edge = cyc;
      drive_inputs();
   endtask

   task automatic drain(input int max_cycles);
      int n = 0;
      while (exp_q.size() != 0 && n < max_cycles) begin
         tick();
         n++;
      end
      check("drain_done", exp_q.size(), 64'd0);
   endtask

   initial begin
      int n;
      out_a = 1'b0;
      drive_inputs();

      // Reset state
      repeat (2) tick();
      check("reset_out_v", out_v, 64'd0);
      check("reset_out_d", out_d, 64'd0);
      check("reset_rdreq", rdreq, 64'd0);
      reset = 1'b1;
      tick();

      // Header-only packet, held without ack
      pop0 = pop_cnt;
      push_word(11'h4A5, 0);
      exp_q.push_back({8'hA5, 24'h000000, 10'h000});
      repeat (6) tick();
      check("hdr_pops", pop_cnt - pop0, 64'd1);
      check("hdr_out_v_held", out_v, 64'd1);
      check("hdr_out_d", out_d, {22'b0, 8'hA5, 34'h0});
      out_a = 1'b1;
      drain(10);
      tick();
      check("hdr_out_v_clear", out_v, 64'd0);

      // Three-word body with ack held high
      v_cycles = 0;
      pop0 = pop_cnt;
      push_word(11'h012, 0); push_word(11'h3FF, 0);
      push_word(11'h155, 0); push_word(11'h40F, 0);
      exp_q.push_back({8'h12, 24'hF557FF, 10'h003});
      drain(20);
      repeat (3) tick();
      check("three_pops", pop_cnt - pop0, 64'd4);
      check("three_v_cycles", v_cycles, 64'd1);
      check("three_latency", v_rise_edge, last_pop_edge);

      // Overflow: five body words, only the first three fit
      pop0 = pop_cnt;
      push_word(11'h033, 0); push_word(11'h001, 0); push_word(11'h002, 0);
      push_word(11'h003, 0); push_word(11'h004, 0); push_word(11'h405, 0);
      exp_q.push_back({8'h33, 24'h300801, 10'h203});
      drain(20);
      tick();
      check("ovf_pops", pop_cnt - pop0, 64'd6);
      check("ovf_trunc_count", last_xfer_d[9:0], 64'h203);

      // Backpressure with a second packet waiting
      out_a = 1'b0;
      pop0 = pop_cnt;
      push_word(11'h012, 0); push_word(11'h3FF, 0);
      push_word(11'h155, 0); push_word(11'h40F, 0);
      push_word(11'h4A5, 0);
      exp_q.push_back({8'h12, 24'hF557FF, 10'h003});
      exp_q.push_back({8'hA5, 24'h000000, 10'h000});
      n = 0;
      while (!out_v && n < 20) begin tick(); n++; end
      check("bp_out_v", out_v, 64'd1);
      hold_d = out_d;
      repeat (5) begin
         tick();
         check("bp_out_d_stable", s_outd, hold_d);
         check("bp_rdreq", s_rdreq, 64'd0);
      end
      check("bp_pops_held", pop_cnt - pop0, 64'd4);
      out_a = 1'b1;
      tick();
      tick();
      check("bp_next_hdr_edge", last_pop_edge, last_xfer_edge + 1);
      check("bp_pops_after", pop_cnt - pop0, 64'd5);
      drain(10);

      // Empty bubbles between every word
      pop0 = pop_cnt;
      push_word(11'h012, 2); push_word(11'h3FF, 2);
      push_word(11'h155, 2); push_word(11'h40F, 2);
      exp_q.push_back({8'h12, 24'hF557FF, 10'h003});
      drain(40);
      check("bubble_pops", pop_cnt - pop0, 64'd4);

      // Asynchronous reset mid-packet
      pop0 = pop_cnt;
      push_word(11'h012, 0); push_word(11'h3FF, 0);
      push_word(11'h155, 0); push_word(11'h40F, 0);
      n = 0;
      while ((pop_cnt - pop0) < 2 && n < 20) begin tick(); n++; end
      check("rst_two_pops", pop_cnt - pop0, 64'd2);
      check("rst_rdreq_before", rdreq, 64'd1);
      #2;
      reset = 1'b0;
      #1;
      check("rst_async_out_v", out_v, 64'd0);
      check("rst_async_rdreq", rdreq, 64'd0);
      fifo.delete();
      head_wait = 0;
      drive_inputs();
      repeat (2) tick();
      reset = 1'b1;
      pop0 = pop_cnt;
      push_word(11'h401, 0);
      exp_q.push_back({8'h01, 34'h0});
      drain(10);
      repeat (2) tick();
      check("rst_fresh_pops", pop_cnt - pop0, 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
